cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_types_pkg.sv | 31 +++
 rtl/cache_perf_counter.sv | 22 ++
 rtl/cache_control.sv | 168 ++++++++++++++++
 tb/tb_cache_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// cache_types_pkg -- shared types and constants for the cache controller.
//   cache_state_t : controller FSM states
//   SEL_*         : datapath mux-select encodings
//   way_mask()    : maps a way number onto the {array1, array2} strobe pair
package cache_types_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    INSTALL
  } cache_state_t;

  // datareadmux_sel: 0 selects array1
  localparam logic SEL_ARRAY1      = 1'b0;
  // datawritemux_sel: 0 = line from memory, 1 = CPU write data
  localparam logic SEL_FILL        = 1'b0;
  localparam logic SEL_CPU_DATA    = 1'b1;
  // adaptermux_sel: 0 = array data
  localparam logic SEL_ADAPT_ARRAY = 1'b0;
  // pmemaddrmux_sel: 0 = CPU address, 1 = victim address
  localparam logic SEL_CPU_ADDR    = 1'b0;
  localparam logic SEL_VICTIM_ADDR = 1'b1;

  // Strobe pair ordered [1]=array1, [0]=array2, matching dirty_out/dirty_load.
  function automatic logic [1:0] way_mask(input logic w);
    return (w == SEL_ARRAY1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_perf_counter.sv
// cache_perf_counter -- saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   inc        : count one event this cycle
//   count      : current value, sticks at all ones
module cache_perf_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_control.sv
// cache_control -- two-way cache controller FSM (IDLE/COMPARE/WRITEBACK/FILL/INSTALL).
//   clk, rst_n            : clock, asynchronous active-low reset
//   mem_read/mem_write    : CPU request, held until mem_resp (both high = write)
//   mem_resp              : one-cycle completion pulse
//   hit, way, lru_out     : lookup result, hitting way, victim way (0 = array1)
//   dirty_out[1:0]        : dirty bits, [1]=array1, [0]=array2
//   array_read, array1_load, array2_load, lru_load, pmdr_load, dirty_load[1:0],
//   *mux_sel, line_fill   : datapath controls
//   pmem_read/pmem_write/pmem_resp : main-memory handshake
//   hit_count/miss_count  : performance counters, only with CACHE_PERF_CNT_EN
// Optional feature macro: CACHE_PERF_CNT_EN
module cache_control
  import cache_types_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic       hit,
  input  logic       way,
  input  logic       lru_out,
  input  logic [1:0] dirty_out,
  output logic       array_read,
  output logic       array1_load,
  output logic       array2_load,
  output logic       lru_load,
  output logic       pmdr_load,
  output logic [1:0] dirty_load,
  output logic       datareadmux_sel,
  output logic       datawritemux_sel,
  output logic       adaptermux_sel,
  output logic       pmemaddrmux_sel,
  output logic       line_fill,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
`endif
);

  if (CNT_WIDTH == 0) begin : g_cnt_width_check
    $error("cache_control: CNT_WIDTH must be nonzero");
  end

  cache_state_t state, next_state;
  logic         req;
  logic         victim_dirty;

  assign req          = mem_read | mem_write;
  assign victim_dirty = |(dirty_out & way_mask(lru_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    mem_resp         = 1'b0;
    array_read       = 1'b0;
    array1_load      = 1'b0;
    array2_load      = 1'b0;
    lru_load         = 1'b0;
    pmdr_load        = 1'b0;
    dirty_load       = 2'b00;
    datareadmux_sel  = 1'b0;
    datawritemux_sel = 1'b0;
    adaptermux_sel   = 1'b0;
    pmemaddrmux_sel  = 1'b0;
    line_fill        = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;

    unique case (state)
      IDLE: begin
        array_read = 1'b1;
        if (req) next_state = COMPARE;
      end

      COMPARE: begin
        // A request abandoned during a miss reaches here with nothing to
        // answer; return quietly rather than start another miss.
        if (!req) begin
          next_state = IDLE;
        end else if (hit) begin
          mem_resp        = 1'b1;
          lru_load        = 1'b1;
          datareadmux_sel = way;
          adaptermux_sel  = SEL_ADAPT_ARRAY;
          if (mem_write) begin
            datawritemux_sel           = SEL_CPU_DATA;
            {array1_load, array2_load} = way_mask(way);
            dirty_load                 = way_mask(way);
          end
          next_state = IDLE;
        end else begin
          next_state = victim_dirty ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        pmem_write      = 1'b1;
        pmemaddrmux_sel = SEL_VICTIM_ADDR;
        datareadmux_sel = lru_out;
        if (pmem_resp) next_state = FILL;
      end

      FILL: begin
        pmem_read       = 1'b1;
        pmemaddrmux_sel = SEL_CPU_ADDR;
        pmdr_load       = 1'b1;
        if (pmem_resp) next_state = INSTALL;
      end

      INSTALL: begin
        line_fill                  = 1'b1;
        datawritemux_sel           = SEL_FILL;
        {array1_load, array2_load} = way_mask(lru_out);
        dirty_load                 = way_mask(lru_out);
        next_state                 = COMPARE;
      end

      default: next_state = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  // Marks the COMPARE right after INSTALL so the re-lookup hit of a miss
  // is not counted as a hit.
  logic refill;
  logic hit_evt, miss_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill <= 1'b0;
    end else begin
      refill <= (state == INSTALL);
    end
  end

  assign hit_evt  = (state == COMPARE) && req && hit && !refill;
  assign miss_evt = (state == COMPARE) && req && !hit;

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_evt),
    .count (hit_count)
  );

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_evt),
    .count (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control -- randomized self-checking bench for cache_control.
// Each CPU request is expanded by a transaction-level model into the list
// of per-cycle output vectors it must produce; counters are modelled as
// event totals clipped at the 4-bit maximum.
module tb_cache_control;
  localparam int unsigned CW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, mem_write, mem_resp;
  logic       hit, way, lru_out;
  logic [1:0] dirty_out;
  logic       array_read, array1_load, array2_load, lru_load, pmdr_load;
  logic [1:0] dirty_load;
  logic       datareadmux_sel, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel;
  logic       line_fill, pmem_read, pmem_write, pmem_resp;
`ifdef CACHE_PERF_CNT_EN
  logic [CW-1:0] hit_count, miss_count;
`endif

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_resp         (mem_resp),
    .hit              (hit),
    .way              (way),
    .lru_out          (lru_out),
    .dirty_out        (dirty_out),
    .array_read       (array_read),
    .array1_load      (array1_load),
    .array2_load      (array2_load),
    .lru_load         (lru_load),
    .pmdr_load        (pmdr_load),
    .dirty_load       (dirty_load),
    .datareadmux_sel  (datareadmux_sel),
    .datawritemux_sel (datawritemux_sel),
    .adaptermux_sel   (adaptermux_sel),
    .pmemaddrmux_sel  (pmemaddrmux_sel),
    .line_fill        (line_fill),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_resp        (pmem_resp)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_resp;
    logic       array_read;
    logic       a1;
    logic       a2;
    logic       lru_load;
    logic       pmdr;
    logic [1:0] dirty;
    logic       drsel;
    logic       dwsel;
    logic       adsel;
    logic       pasel;
    logic       line_fill;
    logic       pr;
    logic       pw;
  } exp_t;

  logic [14:0] obs;
  assign obs = {mem_resp, array_read, array1_load, array2_load, lru_load, pmdr_load,
                dirty_load, datareadmux_sel, datawritemux_sel, adaptermux_sel,
                pmemaddrmux_sel, line_fill, pmem_read, pmem_write};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned model_hits = 0;
  int unsigned model_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned x);
    return (x > 15) ? 15 : x;
  endfunction

  function automatic exp_t idle_vec();
    exp_t e = '0;
    e.array_read = 1'b1;
    return e;
  endfunction

  // Completion cycle: reads steer the data mux to the hitting way; writes also
  // load that way's array and set its dirty bit.
  function automatic exp_t hit_vec(input bit wr, input bit w);
    exp_t e = '0;
    e.mem_resp = 1'b1;
    e.lru_load = 1'b1;
    e.drsel    = w;
    if (wr) begin
      e.dwsel = 1'b1;
      if (w == 1'b0) begin e.a1 = 1'b1; e.dirty = 2'b10; end
      else           begin e.a2 = 1'b1; e.dirty = 2'b01; end
    end
    return e;
  endfunction

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic cycle(input string tag, input exp_t e);
    #1 check(tag, 32'(obs), 32'(e));
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
`ifdef CACHE_PERF_CNT_EN
    check({tag, "_hit_count"},  32'(hit_count),  32'(sat(model_hits)));
    check({tag, "_miss_count"}, 32'(miss_count), 32'(sat(model_misses)));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic run_txn(input bit rd, input bit wr, input bit hit_i, input bit way_i,
                         input bit lru_i, input logic [1:0] dirty_i,
                         input int unsigned wb_lat, input int unsigned fill_lat,
                         input bit drop);
    exp_t e;
    bit victim_dirty;
    victim_dirty = (lru_i == 1'b0) ? dirty_i[1] : dirty_i[0];

    mem_read = rd; mem_write = wr;
    hit = hit_i; way = way_i; lru_out = lru_i; dirty_out = dirty_i;
    pmem_resp = 1'($urandom_range(0, 1));
    cycle("idle_req", idle_vec());

    pmem_resp = 1'($urandom_range(0, 1));
    if (hit_i) begin
      model_hits++;
      cycle("cmp_hit", hit_vec(wr, way_i));
    end else begin
      model_misses++;
      cycle("cmp_miss", '0);
      if (victim_dirty) begin
        for (int i = 0; i < int'(wb_lat); i++) begin
          if (drop && i == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
          pmem_resp = (i == int'(wb_lat) - 1);
          e = '0; e.pw = 1'b1; e.pasel = 1'b1; e.drsel = lru_i;
          cycle("writeback", e);
        end
      end
      for (int i = 0; i < int'(fill_lat); i++) begin
        if (drop && i == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
        pmem_resp = (i == int'(fill_lat) - 1);
        e = '0; e.pr = 1'b1; e.pmdr = 1'b1;
        cycle("fill", e);
      end
      pmem_resp = 1'($urandom_range(0, 1));
      e = '0; e.line_fill = 1'b1;
      if (lru_i == 1'b0) begin e.a1 = 1'b1; e.dirty = 2'b10; end
      else               begin e.a2 = 1'b1; e.dirty = 2'b01; end
      cycle("install", e);
      hit = 1'b1; way = lru_i;
      pmem_resp = 1'($urandom_range(0, 1));
      if (drop) cycle("recmp_dropped", '0);
      else      cycle("recmp_hit", hit_vec(wr, lru_i));
    end

    mem_read = 1'b0; mem_write = 1'b0;
    pmem_resp = 1'($urandom_range(0, 1));
    cycle("back_idle", idle_vec());
    check_counters("txn");
  endtask

  task automatic reset_in_fill();
    exp_t e;
    mem_read = 1'b1; mem_write = 1'b0;
    hit = 1'b0; way = 1'b0; lru_out = 1'b0; dirty_out = 2'b00; pmem_resp = 1'b0;
    cycle("rst_idle_req", idle_vec());
    model_misses++;
    cycle("rst_cmp_miss", '0);
    e = '0; e.pr = 1'b1; e.pmdr = 1'b1;
    #1 check("rst_fill_before", 32'(obs), 32'(e));
    rst_n = 1'b0;
    model_hits = 0; model_misses = 0;
    #1 check("rst_async_outputs", 32'(obs), 32'(idle_vec()));
    check_counters("rst_async");
    @(negedge clk);
    mem_read = 1'b0;
    rst_n = 1'b1;
    cycle("rst_released_idle", idle_vec());
    cycle("rst_stays_idle", idle_vec());
    check_counters("rst_after");
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    hit = 1'b0; way = 1'b0; lru_out = 1'b0; dirty_out = 2'b00; pmem_resp = 1'b0;
    #1 check("reset_outputs", 32'(obs), 32'(idle_vec()));
    check_counters("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // read hit way 1
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1, 1, 1'b0);
    // write hit way 0
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1, 1, 1'b0);
    // read miss, clean victim way 1, memory answers in the fifth fill cycle
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1, 5, 1'b0);
    // write miss, dirty victim way 0
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 3, 2, 1'b0);
    // read+write together behaves as a write
    run_txn(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1, 1, 1'b0);
    // request dropped during a dirty miss
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2, 2, 1'b1);

    for (int n = 0; n < 120; n++) begin
      int unsigned op;
      bit rd, wr, h;
      op = $urandom_range(0, 3);
      rd = (op != 1);
      wr = (op == 1) || (op == 2);
      h  = 1'($urandom_range(0, 1));
      run_txn(rd, wr, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(1, 4),
              !h && ($urandom_range(0, 7) == 0));
    end

    reset_in_fill();

    // 20 back-to-back hits drive the 4-bit hit counter into saturation
    for (int n = 0; n < 20; n++) begin
      run_txn(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 2'b00, 1, 1, 1'b0);
    end
`ifdef CACHE_PERF_CNT_EN
    check("hit_count_saturated", 32'(hit_count), 32'hF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
